// File: rtl/mcse_ahb_pkg.sv
// Shared AHB-Lite encodings and responder FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcse_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } fsm_state_e;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Maps HSIZE and low address bits to little-endian byte enables plus a misalignment flag.
// Latency: combinational.
// Backpressure: none.
module ahb_byte_lane_decode #(
    parameter int BPW = 4,
    parameter int LW  = $clog2(BPW)
) (
    input  logic [2:0]     size,
    input  logic [LW-1:0]  addr_lo,
    output logic [BPW-1:0] byte_en,
    output logic           align_err
);

    // A lane belongs to the transfer when it shares the address bits above the size boundary.
    always_comb begin
        byte_en = '0;
        for (int i = 0; i < BPW; i++) begin
            byte_en[i] = ((i >> size) == (int'(addr_lo) >> size));
        end
        align_err = ((int'(addr_lo) & ((1 << size) - 1)) != 0);
    end

endmodule

// File: rtl/mcse_ahb_fw_responder.sv
// AHB-Lite firmware image store: word SRAM behind BASE_ADDR with wait states, ERROR responses and write lock.
// Latency: WAIT_STATES stall cycles per valid data phase; errors take ERR1 (stall) + ERR2.
// Backpressure: HREADYOUT low in WAIT/ERR1; a new address phase is taken whenever HREADYOUT is high.
module mcse_ahb_fw_responder
    import mcse_ahb_pkg::*;
#(
    parameter int                         pAHB_DATA_WIDTH  = 32,
    parameter int                         pAHB_ADDR_WIDTH  = 32,
    parameter int                         pAHB_HRESP_WIDTH = 2,
    parameter logic [pAHB_ADDR_WIDTH-1:0] BASE_ADDR        = 32'h4000_0000,
    parameter int                         DEPTH            = 256,
    parameter int                         WAIT_STATES      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         I_hsel,
    input  logic [pAHB_ADDR_WIDTH-1:0]   I_haddr,
    input  logic [1:0]                   I_htrans,
    input  logic                         I_hwrite,
    input  logic [2:0]                   I_hsize,
    input  logic [2:0]                   I_hburst,
    input  logic [3:0]                   I_hprot,
    input  logic                         I_hmastlock,
    input  logic                         I_hnonsec,
    input  logic [pAHB_DATA_WIDTH-1:0]   I_hwdata,
    input  logic                         I_hready,
    input  logic                         wr_lock,
    output logic [pAHB_DATA_WIDTH-1:0]   O_hrdata,
    output logic                         O_hreadyout,
    output logic [pAHB_HRESP_WIDTH-1:0]  O_hresp,
    output logic [7:0]                   O_err_count
);

    localparam int BPW = pAHB_DATA_WIDTH / 8;
    localparam int LW  = $clog2(BPW);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [pAHB_ADDR_WIDTH:0] SPAN = (pAHB_ADDR_WIDTH+1)'(DEPTH * BPW);

    fsm_state_e state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       pend, pend_nxt;

    logic           d_write;
    logic [AW-1:0]  d_word;
    logic [BPW-1:0] d_be;

    logic [pAHB_ADDR_WIDTH-1:0] offs;
    logic                       in_range;
    logic [BPW-1:0]             be;
    logic                       align_err;
    logic                       ready_int;
    logic                       accept;
    logic                       acc_err;
    logic                       complete;
    logic [pAHB_DATA_WIDTH-1:0] mem [DEPTH];

    logic unused_ok;
    assign unused_ok = ^{I_hburst, I_hprot, I_hmastlock, I_htrans[0]};

    ahb_byte_lane_decode #(.BPW(BPW), .LW(LW)) u_lane (
        .size      (I_hsize),
        .addr_lo   (I_haddr[LW-1:0]),
        .byte_en   (be),
        .align_err (align_err)
    );

    assign offs      = I_haddr - BASE_ADDR;
    assign in_range  = (I_haddr >= BASE_ADDR) && ({1'b0, offs} < SPAN);
    assign ready_int = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept    = I_hsel & I_hready & I_htrans[1] & ready_int;
    assign acc_err   = ~in_range | (I_hsize > 3'(LW)) | align_err | (I_hwrite & (wr_lock | I_hnonsec));
    // pend marks a registered good transfer; it completes on the first IDLE cycle after its waits.
    assign complete  = pend & (state == ST_IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pend_nxt     = pend;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                pend_nxt  = 1'b0;
                if (accept) begin
                    if (acc_err) begin
                        state_nxt = ST_ERR1;
                    end else begin
                        pend_nxt = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_nxt    = ST_WAIT;
                            wait_cnt_nxt = 4'(WAIT_STATES);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            pend        <= 1'b0;
            d_write     <= 1'b0;
            d_word      <= '0;
            d_be        <= '0;
            O_err_count <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            pend     <= pend_nxt;
            if (accept) begin
                d_write <= I_hwrite;
                d_word  <= offs[LW +: AW];
                d_be    <= be;
            end
            if ((state == ST_ERR2) && (O_err_count != 8'hFF)) begin
                O_err_count <= O_err_count + 8'd1;
            end
        end
    end

    // Store is deliberately left out of reset so the image survives a bus reset.
    always_ff @(posedge clk) begin
        if (complete && d_write) begin
            for (int b = 0; b < BPW; b++) begin
                if (d_be[b]) mem[d_word][8*b +: 8] <= I_hwdata[8*b +: 8];
            end
        end
    end

    assign O_hrdata    = (complete && !d_write) ? mem[d_word] : '0;
    assign O_hreadyout = ready_int;
    assign O_hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ?
                         pAHB_HRESP_WIDTH'(HRESP_ERROR) : pAHB_HRESP_WIDTH'(HRESP_OKAY);

endmodule

// File: tb/tb_mcse_ahb_fw_responder.sv
// Bench for mcse_ahb_fw_responder: one instance with 1 wait state, one with none, sharing a bus.
module tb_mcse_ahb_fw_responder;

    localparam longint BASE = 64'h4000_0000;
    localparam int     NWORDS = 256;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
        logic        nonsec;
    } xfer_t;

    typedef struct {
        xfer_t       x;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          stalls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic        hnonsec = 1'b0;
    logic [31:0] hwdata = '0;
    logic        wr_lock = 1'b0;
    int          cur = 0;

    logic        hsel0, hsel1, hready_bus;
    logic [31:0] rd0, rd1, hrdata_bus;
    logic        ro0, ro1;
    logic [1:0]  rs0, rs1, hresp_bus;
    logic [7:0]  ec0, ec1, ec_bus;

    assign hsel0      = hsel && (cur == 0);
    assign hsel1      = hsel && (cur == 1);
    assign hready_bus = (cur == 0) ? ro0 : ro1;
    assign hrdata_bus = (cur == 0) ? rd0 : rd1;
    assign hresp_bus  = (cur == 0) ? rs0 : rs1;
    assign ec_bus     = (cur == 0) ? ec0 : ec1;

    mcse_ahb_fw_responder #(.WAIT_STATES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .I_hsel(hsel0), .I_haddr(haddr), .I_htrans(htrans),
        .I_hwrite(hwrite), .I_hsize(hsize), .I_hburst(hburst), .I_hprot(4'b0011),
        .I_hmastlock(1'b0), .I_hnonsec(hnonsec), .I_hwdata(hwdata), .I_hready(hready_bus),
        .wr_lock(wr_lock), .O_hrdata(rd0), .O_hreadyout(ro0), .O_hresp(rs0), .O_err_count(ec0)
    );

    mcse_ahb_fw_responder #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .I_hsel(hsel1), .I_haddr(haddr), .I_htrans(htrans),
        .I_hwrite(hwrite), .I_hsize(hsize), .I_hburst(hburst), .I_hprot(4'b0011),
        .I_hmastlock(1'b0), .I_hnonsec(hnonsec), .I_hwdata(hwdata), .I_hready(hready_bus),
        .wr_lock(wr_lock), .O_hrdata(rd1), .O_hreadyout(ro1), .O_hresp(rs1), .O_err_count(ec1)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    xfer_t       xq[$];
    logic [31:0] res_rdata[$];
    logic [1:0]  res_resp[$];
    int          res_stalls[$];
    logic [31:0] mem_m [2][NWORDS];
    int          merr [2];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic xfer_t mk(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                                 input logic [31:0] wd, input logic lk, input logic ns);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.write = wr; x.size = sz;
        x.addr = a; x.wdata = wd; x.lock = lk; x.nonsec = ns;
        return x;
    endfunction

    function automatic vec_t mkv(input xfer_t x, input logic [31:0] rdv, input logic [1:0] rsv, input int st);
        vec_t v;
        v.x = x; v.rdata = rdv; v.resp = rsv; v.stalls = st;
        return v;
    endfunction

    // Reference rules: legal window, legal size, natural alignment, writable image.
    function automatic bit m_err(input xfer_t x);
        longint a = longint'(x.addr);
        bit oor = (a < BASE) || (a >= BASE + NWORDS * 4);
        bit bsz = (x.size > 3'd2);
        bit mis = !bsz && ((a % (64'd1 << x.size)) != 0);
        bit wl  = x.write && (x.lock || x.nonsec);
        return oor || bsz || mis || wl;
    endfunction

    function automatic int m_word(input xfer_t x);
        return int'((longint'(x.addr) - BASE) / 4);
    endfunction

    task automatic m_write(input int k, input xfer_t x);
        int st = int'(x.addr[1:0]);
        int nb = 1 << x.size;
        int w  = m_word(x);
        for (int b = st; b < st + nb; b++) mem_m[k][w][8*b +: 8] = x.wdata[8*b +: 8];
    endtask

    task automatic drive_addr(input int i);
        if (i < 0) begin
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd0;
        end else begin
            hsel = xq[i].sel; htrans = xq[i].trans; hwrite = xq[i].write; haddr = xq[i].addr;
            hsize = xq[i].size; wr_lock = xq[i].lock; hnonsec = xq[i].nonsec;
        end
    endtask

    // Pipelined AHB driver: next address phase is presented while the previous data phase runs.
    task automatic run_q(input int k);
        int          n, a, d, stalls, guard, es;
        bit          rdy, trk, e;
        logic [31:0] rd, exp_rd;
        logic [1:0]  rs, exp_rs;
        n = xq.size(); a = 0; d = -1; stalls = 0; guard = 0; es = 0; trk = 0; e = 0;
        cur = k;
        res_rdata.delete(); res_resp.delete(); res_stalls.delete();
        drive_addr(n > 0 ? 0 : -1);
        while ((a < n || d >= 0) && guard < 5000) begin
            guard++;
            @(negedge clk);
            rdy = hready_bus; rd = hrdata_bus; rs = hresp_bus;
            if (d >= 0) begin
                if (!rdy) begin
                    stalls++;
                    chk($sformatf("x%0d.stall_resp", d), {30'd0, rs}, e ? 32'd1 : 32'd0);
                    chk($sformatf("x%0d.stall_rdata", d), rd, 32'd0);
                end else begin
                    exp_rd = 32'd0;
                    exp_rs = e ? 2'b01 : 2'b00;
                    if (trk && !e) begin
                        if (xq[d].write) m_write(k, xq[d]);
                        else exp_rd = mem_m[k][m_word(xq[d])];
                    end
                    if (e && merr[k] < 255) merr[k]++;
                    chk($sformatf("x%0d.stalls", d), 32'(stalls), 32'(es));
                    chk($sformatf("x%0d.resp", d), {30'd0, rs}, {30'd0, exp_rs});
                    chk($sformatf("x%0d.rdata", d), rd, exp_rd);
                    res_rdata.push_back(rd); res_resp.push_back(rs); res_stalls.push_back(stalls);
                end
            end
            @(posedge clk); #1;
            if (rdy) begin
                stalls = 0;
                if (a < n) begin
                    d = a; a++;
                    trk = xq[d].sel && xq[d].trans[1];
                    e   = trk && m_err(xq[d]);
                    es  = !trk ? 0 : (e ? 1 : (k == 0 ? 1 : 0));
                    hwdata = xq[d].wdata;
                end else begin
                    d = -1;
                end
                drive_addr(a < n ? a : -1);
            end
        end
        if (guard >= 5000) chk("run_q_timeout", 32'd1, 32'd0);
        chk($sformatf("dut%0d.err_count", k), {24'd0, ec_bus}, 32'(merr[k]));
    endtask

    function automatic xfer_t rnd_x();
        xfer_t x;
        int    r = int'($urandom_range(0, 99));
        x.sel    = (r >= 5);
        x.trans  = (r < 12) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        x.write  = 1'($urandom_range(0, 1));
        x.size   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        case ($urandom_range(0, 19))
            0:       x.addr = 32'h4000_0400 + 32'($urandom_range(0, 15));
            1:       x.addr = 32'h3FFF_FFFC;
            default: x.addr = 32'h4000_0000 + 32'($urandom_range(0, 63));
        endcase
        if (x.size <= 3'd2 && $urandom_range(0, 9) < 7) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        x.wdata  = $urandom;
        x.lock   = ($urandom_range(0, 5) == 0);
        x.nonsec = ($urandom_range(0, 5) == 0);
        return x;
    endfunction

    vec_t  vt[16];
    xfer_t xi;

    initial begin
        vt[0]  = mkv(mk(32'h4000_0010, 1, 3'd2, 32'hDEADBEEF, 0, 0), 32'h0, 2'b00, 1);
        vt[1]  = mkv(mk(32'h4000_0010, 0, 3'd2, 32'h0, 0, 0), 32'hDEADBEEF, 2'b00, 1);
        vt[2]  = mkv(mk(32'h4000_0012, 1, 3'd1, 32'hA5A5A5A5, 0, 0), 32'h0, 2'b00, 1);
        vt[3]  = mkv(mk(32'h4000_0010, 0, 3'd2, 32'h0, 0, 0), 32'hA5A5BEEF, 2'b00, 1);
        vt[4]  = mkv(mk(32'h4000_0400, 0, 3'd2, 32'h0, 0, 0), 32'h0, 2'b01, 1);
        vt[5]  = mkv(mk(32'h4000_0000, 1, 3'd2, 32'h5555AAAA, 0, 0), 32'h0, 2'b00, 1);
        vt[6]  = mkv(mk(32'h4000_0000, 1, 3'd2, 32'h12345678, 1, 0), 32'h0, 2'b01, 1);
        vt[7]  = mkv(mk(32'h4000_0000, 0, 3'd2, 32'h0, 0, 0), 32'h5555AAAA, 2'b00, 1);
        vt[8]  = mkv(mk(32'h4000_0000, 1, 3'd2, 32'h12345678, 0, 1), 32'h0, 2'b01, 1);
        vt[9]  = mkv(mk(32'h4000_0000, 0, 3'd2, 32'h0, 1, 0), 32'h5555AAAA, 2'b00, 1);
        vt[10] = mkv(mk(32'h4000_0011, 0, 3'd1, 32'h0, 0, 0), 32'h0, 2'b01, 1);
        vt[11] = mkv(mk(32'h4000_0000, 0, 3'd3, 32'h0, 0, 0), 32'h0, 2'b01, 1);
        vt[12] = mkv(mk(32'h4000_0013, 1, 3'd0, 32'h11223344, 0, 0), 32'h0, 2'b00, 1);
        vt[13] = mkv(mk(32'h4000_0010, 0, 3'd2, 32'h0, 0, 0), 32'h11A5BEEF, 2'b00, 1);
        xi = mk(32'h4000_0010, 0, 3'd2, 32'h0, 0, 0); xi.trans = 2'b00;
        vt[14] = mkv(xi, 32'h0, 2'b00, 0);
        vt[15] = mkv(mk(32'h3FFF_FFFC, 0, 3'd2, 32'h0, 0, 0), 32'h0, 2'b01, 1);
        merr[0] = 0; merr[1] = 0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst.hreadyout_a", {31'd0, ro0}, 32'd1);
        chk("rst.hresp_a", {30'd0, rs0}, 32'd0);
        chk("rst.hrdata_a", rd0, 32'd0);
        chk("rst.err_count_a", {24'd0, ec0}, 32'd0);
        chk("rst.hreadyout_b", {31'd0, ro1}, 32'd1);
        chk("rst.err_count_b", {24'd0, ec1}, 32'd0);
        @(posedge clk); #1;

        // Directed vectors on the one-wait-state instance.
        xq.delete();
        for (int i = 0; i < 16; i++) xq.push_back(vt[i].x);
        run_q(0);
        for (int i = 0; i < 16 && i < res_rdata.size(); i++) begin
            chk($sformatf("vec%0d.rdata", i), res_rdata[i], vt[i].rdata);
            chk($sformatf("vec%0d.resp", i), {30'd0, res_resp[i]}, {30'd0, vt[i].resp});
            chk($sformatf("vec%0d.stalls", i), 32'(res_stalls[i]), 32'(vt[i].stalls));
        end
        chk("vec.err_count", {24'd0, ec0}, 32'd6);

        // Zero-wait INCR4 burst: preload 1..4, then NONSEQ + 3 SEQ reads back-to-back.
        xq.delete();
        for (int i = 0; i < 4; i++) xq.push_back(mk(32'h4000_0020 + 32'(4 * i), 1, 3'd2, 32'(i + 1), 0, 0));
        run_q(1);
        hburst = 3'b011;
        xq.delete();
        for (int i = 0; i < 4; i++) begin
            xi = mk(32'h4000_0020 + 32'(4 * i), 0, 3'd2, 32'h0, 0, 0);
            if (i > 0) xi.trans = 2'b11;
            xq.push_back(xi);
        end
        run_q(1);
        hburst = 3'b000;
        for (int i = 0; i < 4 && i < res_rdata.size(); i++) begin
            chk($sformatf("burst%0d.rdata", i), res_rdata[i], 32'(i + 1));
            chk($sformatf("burst%0d.stalls", i), 32'(res_stalls[i]), 32'd0);
        end

        // Reset asserted in the ERR1 cycle.
        cur = 0;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h4000_0400;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        chk("err1.hreadyout", {31'd0, ro0}, 32'd0);
        chk("err1.hresp", {30'd0, rs0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_err1.hreadyout", {31'd0, ro0}, 32'd1);
        chk("rst_err1.hresp", {30'd0, rs0}, 32'd0);
        chk("rst_err1.hrdata", rd0, 32'd0);
        chk("rst_err1.err_count", {24'd0, ec0}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        merr[0] = 0; merr[1] = 0;
        xq.delete();
        xq.push_back(mk(32'h4000_0010, 0, 3'd2, 32'h0, 0, 0));
        run_q(0);
        if (res_rdata.size() > 0) chk("post_rst.rdata", res_rdata[0], 32'h11A5BEEF);

        // Randomized traffic against the reference model on both instances.
        for (int k = 0; k < 2; k++) begin
            xq.delete();
            for (int w = 0; w < 16; w++) xq.push_back(mk(32'h4000_0000 + 32'(4 * w), 1, 3'd2, $urandom, 0, 0));
            run_q(k);
            xq.delete();
            for (int i = 0; i < 300; i++) xq.push_back(rnd_x());
            run_q(k);
        end

        // Error counter saturation.
        xq.delete();
        for (int i = 0; i < 260; i++) xq.push_back(mk(32'h4000_0400, 0, 3'd2, 32'h0, 0, 0));
        run_q(1);
        chk("err_count_saturated", {24'd0, ec1}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcse_ahb_fw_responder.md
Name: mcse_ahb_fw_responder

Overview:
AHB-Lite subordinate (responder) that answers the MCSE system-side AHB requester port. It is the firmware/boot-image store the boot controller and firmware-hash engine read over the system bus. It provides word-addressed SRAM behind a base address, programmable wait states, two-cycle ERROR responses, and a write-lock input so the image becomes read-only after provisioning.

Parameters:
- pAHB_DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- pAHB_ADDR_WIDTH, 32, address bus width.
- pAHB_HRESP_WIDTH, 2, HRESP width; 2'b00 = OKAY, 2'b01 = ERROR.
- BASE_ADDR, 32'h4000_0000, first byte address decoded; aligned to DEPTH*bytes-per-word.
- DEPTH, 256, number of words in the store.
- WAIT_STATES, 1, number of HREADYOUT=0 cycles inserted in every valid data phase; range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- I_hsel  in  1  subordinate select.
- I_haddr  in  pAHB_ADDR_WIDTH  address.
- I_htrans  in  2  transfer type.
- I_hwrite  in  1  1 = write.
- I_hsize  in  3  transfer size.
- I_hburst  in  3  burst type; ignored, each beat is decoded independently.
- I_hprot  in  4  protection; ignored.
- I_hmastlock  in  1  ignored.
- I_hnonsec  in  1  1 = non-secure; gives ERROR on writes.
- I_hwdata  in  pAHB_DATA_WIDTH  write data, sampled in the data phase.
- I_hready  in  1  bus HREADY.
- wr_lock  in  1  1 = all writes give ERROR.
- O_hrdata  out  pAHB_DATA_WIDTH  read data.
- O_hreadyout  out  1  subordinate ready.
- O_hresp  out  pAHB_HRESP_WIDTH  response.
- O_err_count  out  8  saturating count of ERROR responses.

Behaviour:
- Accept condition: an address phase is accepted when I_hsel & I_hready & I_htrans[1], i.e. NONSEQ or SEQ. At acceptance, register addr, write, size and the error decision.
- IDLE/BUSY transfers, and unselected transfers, get a zero-wait OKAY. No state change.
- Error decision is made at acceptance. An access errors if any of the following holds:
  - address is outside [BASE_ADDR, BASE_ADDR + DEPTH*bytes-per-word);
  - hsize exceeds log2(bytes-per-word);
  - address is not aligned to hsize;
  - the access is a write and (wr_lock | I_hnonsec).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: O_hreadyout=1, O_hresp=OKAY. On a valid accept: go to WAIT if WAIT_STATES>0, else complete the data phase in the next cycle (stay in IDLE). On an error accept: go to ERR1.
  - WAIT: O_hreadyout=0, O_hresp=OKAY. A wait counter loads WAIT_STATES and decrements; after WAIT_STATES cycles, the next cycle is the completing cycle with O_hreadyout=1.
  - ERR1: O_hreadyout=0, O_hresp=ERROR. Next state is ERR2.
  - ERR2: O_hreadyout=1, O_hresp=ERROR. O_err_count increments, saturating at 255. A new address phase may be accepted in this cycle.
- Pipelining: a new address phase is accepted in the same cycle an earlier data phase completes (I_hready=1). This gives back-to-back transfers with no idle cycle when WAIT_STATES=0.
- Writes:
  - commit on the completing data-phase cycle;
  - byte lanes come from size and addr low bits, little-endian;
  - only enabled lanes of I_hwdata are written;
  - errored writes never modify the store.
- Reads:
  - O_hrdata shows the full addressed word on the completing cycle; all lanes are driven and the requester selects.
  - O_hrdata is 0 in every other cycle, including ERR1/ERR2.
  - A read immediately after a write to the same word returns the new data.
- wr_lock and I_hnonsec are sampled only at acceptance. A lock change during a data phase does not affect that transfer.
- Reset (asynchronous, at any time, including mid-WAIT or mid-ERR):
  - state goes to IDLE, O_hreadyout=1, O_hresp=OKAY, O_hrdata=0, O_err_count=0, wait counter 0;
  - store contents are not reset.

Decomposition:
- Package mcse_ahb_pkg holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP encodings;
  - HSIZE encodings;
  - the FSM state enum typedef.
- Sub-module ahb_byte_lane_decode (combinational) maps size and addr low bits to a byte-enable vector and an alignment-error flag.
- Storage is an inferred array inside the top module.

Test Plan:
1. Write then read, WAIT_STATES=1: write 32'hDEADBEEF to 0x4000_0010 (word, NONSEQ), then read the same address -> each data phase shows one HREADYOUT=0 cycle, then HRDATA=32'hDEADBEEF with OKAY.
2. Byte write: halfword 16'hA5A5 at 0x4000_0012 over 32'hDEADBEEF -> subsequent read returns 32'hA5A5BEEF.
3. Out-of-range read at 0x4000_0400 (DEPTH=256) -> ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01); O_err_count=1; HRDATA=0.
4. wr_lock=1: word write 32'h1234_5678 to 0x4000_0000 -> two-cycle ERROR; a following read returns the prior value. Repeat with wr_lock=0 and I_hnonsec=1 -> ERROR.
5. WAIT_STATES=0 burst: INCR4 reads at 0x4000_0020..2C, preloaded with 1,2,3,4 -> four consecutive OKAY cycles returning 1,2,3,4 with no stall.
6. Assert rst_n=0 during the ERR1 cycle -> outputs return to HREADYOUT=1, HRESP=00, O_err_count=0 immediately; a read after release returns the previously written data.
